seg7_scan_decoder: RTL

- Receive-side counterpart of the multiplexed 7-segment display driver.
- Passively samples the `an`/`seg` scan bus and rebuilds the four displayed characters as hex nibbles plus blank flags.
- Raises a strobe each time a complete, consistent frame has been observed.
- Used for on-board loopback and self-check of the step/distance/time display path, and as the bench's display monitor.

---
 rtl/seg7_pkg.sv | 27 ++
 rtl/seg7_glyph_decode.sv | 41 ++++
 rtl/seg7_scan_decoder.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment scan decoder: active-low glyph
// patterns {g,f,e,d,c,b,a}, FSM state type and digit count.
package seg7_pkg;

    localparam int unsigned DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_e;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational active-low segment pattern to hex nibble decoder with blank
// and unrecognised-glyph flags.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] nibble_o,
    output logic       blank_o,
    output logic       err_o
);

    always_comb begin
        nibble_o = 4'hF;
        blank_o  = 1'b0;
        err_o    = 1'b0;
        case (seg_i)
            SEG_0:     nibble_o = 4'h0;
            SEG_1:     nibble_o = 4'h1;
            SEG_2:     nibble_o = 4'h2;
            SEG_3:     nibble_o = 4'h3;
            SEG_4:     nibble_o = 4'h4;
            SEG_5:     nibble_o = 4'h5;
            SEG_6:     nibble_o = 4'h6;
            SEG_7:     nibble_o = 4'h7;
            SEG_8:     nibble_o = 4'h8;
            SEG_9:     nibble_o = 4'h9;
            SEG_A:     nibble_o = 4'hA;
            SEG_B:     nibble_o = 4'hB;
            SEG_C:     nibble_o = 4'hC;
            SEG_D:     nibble_o = 4'hD;
            SEG_E:     nibble_o = 4'hE;
            SEG_F:     nibble_o = 4'hF;
            SEG_BLANK: begin
                nibble_o = 4'h0;
                blank_o  = 1'b1;
            end
            default:   err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Passive monitor of a multiplexed 7-segment scan bus; rebuilds the four digits.
// Define SEG7_SCAN_TIMEOUT_EN to build the stall timeout counter.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    output logic [15:0] digits,
    output logic [3:0]  blank,
    output logic        frame_valid,
    output logic        glyph_err,
    output logic        an_err,
    output logic        stalled
);

    localparam logic [7:0] SettleMax = 8'(SETTLE_CYCLES);

    logic [3:0]  an_s1_q, an_s2_q;
    logic [6:0]  seg_s1_q, seg_s2_q;
    logic [7:0]  cnt_q, cnt_d;
    state_e      state_q, state_d;
    logic [15:0] stage_nib_q, stage_nib_d;
    logic [3:0]  stage_blank_q, stage_blank_d;
    logic [3:0]  mask_q, mask_d;
    logic [15:0] digits_q, digits_d;
    logic [3:0]  blank_q, blank_d;
    logic        fv_q, fv_d;
    logic        glyph_err_q, glyph_err_d;
    logic        an_err_q, an_err_d;
    logic        bus_change, an_valid;
    logic [1:0]  pos;
    logic [3:0]  dec_nib;
    logic        dec_blank, dec_err;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            an_s1_q  <= 4'hF;
            an_s2_q  <= 4'hF;
            seg_s1_q <= 7'h7F;
            seg_s2_q <= 7'h7F;
        end else begin
            an_s1_q  <= an;
            an_s2_q  <= an_s1_q;
            seg_s1_q <= seg;
            seg_s2_q <= seg_s1_q;
        end
    end

    // The synced bus changes next cycle exactly when stage 1 differs from stage 2.
    assign bus_change = {an_s1_q, seg_s1_q} != {an_s2_q, seg_s2_q};

    always_comb begin
        if (bus_change) begin
            cnt_d = 8'd0;
        end else if (cnt_q == SettleMax) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_comb begin
        an_valid = 1'b1;
        pos      = 2'd0;
        case (an_s2_q)
            4'b1110: pos = 2'd0;
            4'b1101: pos = 2'd1;
            4'b1011: pos = 2'd2;
            4'b0111: pos = 2'd3;
            default: an_valid = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (an_s2_q != 4'hF) begin
                    state_d = (cnt_d == SettleMax) ? CAPTURE : SETTLE;
                end
            end
            SETTLE: begin
                if (an_s2_q == 4'hF) begin
                    state_d = IDLE;
                end else if (cnt_d == SettleMax) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE, HOLD: begin
                if (bus_change) begin
                    state_d = (an_s1_q == 4'hF) ? IDLE : SETTLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    seg7_glyph_decode u_glyph_decode (
        .seg_i    (seg_s2_q),
        .nibble_o (dec_nib),
        .blank_o  (dec_blank),
        .err_o    (dec_err)
    );

    always_comb begin
        stage_nib_d   = stage_nib_q;
        stage_blank_d = stage_blank_q;
        mask_d        = mask_q;
        digits_d      = digits_q;
        blank_d       = blank_q;
        fv_d          = 1'b0;
        glyph_err_d   = glyph_err_q;
        an_err_d      = an_err_q;
        if (mask_q == 4'hF) begin
            digits_d = stage_nib_q;
            blank_d  = stage_blank_q;
            fv_d     = 1'b1;
            mask_d   = 4'h0;
        end
        if (state_q == CAPTURE) begin
            if (!an_valid) begin
                an_err_d = 1'b1;
            end else begin
                stage_nib_d[{pos, 2'b00} +: 4] = dec_nib;
                stage_blank_d[pos]             = dec_blank;
                mask_d[pos]                    = 1'b1;
                glyph_err_d                    = glyph_err_q | dec_err;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt_q         <= 8'd0;
            state_q       <= IDLE;
            stage_nib_q   <= 16'h0;
            stage_blank_q <= 4'h0;
            mask_q        <= 4'h0;
            digits_q      <= 16'h0;
            blank_q       <= 4'hF;
            fv_q          <= 1'b0;
            glyph_err_q   <= 1'b0;
            an_err_q      <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            stage_nib_q   <= stage_nib_d;
            stage_blank_q <= stage_blank_d;
            mask_q        <= mask_d;
            digits_q      <= digits_d;
            blank_q       <= blank_d;
            fv_q          <= fv_d;
            glyph_err_q   <= glyph_err_d;
            an_err_q      <= an_err_d;
        end
    end

    assign digits      = digits_q;
    assign blank       = blank_q;
    assign frame_valid = fv_q;
    assign glyph_err   = glyph_err_q;
    assign an_err      = an_err_q;

`ifdef SEG7_SCAN_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT_CYCLES);
    localparam logic [TmoW-1:0] TmoOne = TmoW'(1);

    logic [TmoW-1:0] tmo_q, tmo_d;

    always_comb begin
        if (state_q == CAPTURE) begin
            tmo_d = '0;
        end else if (tmo_q == TmoMax) begin
            tmo_d = tmo_q;
        end else begin
            tmo_d = tmo_q + TmoOne;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign stalled = (tmo_q == TmoMax);
`else
    assign stalled = 1'b0;
`endif

endmodule
